mem_fifo_ctrl: RTL and testbench
================================

Name: mem_fifo_ctrl

Overview:
- Flow-control stage directly upstream of the 4x12 `Memory` block (2-element array of {X:1, Y:5}).
- Turns the memory into a synchronous FIFO:
  - accepts a valid/ready enqueue stream and drives the memory's WADDR/WDATA/WE;
  - drives RADDR and presents the memory's combinational RDATA as a valid/ready dequeue stream.
- Holds only pointers and flags; all payload storage is in `Memory`.

Parameters:
- ADDR_W, 2, memory address width; must match Memory RADDR/WADDR width.
- DEPTH, 4, number of entries; must equal 2**ADDR_W (checked at elaboration, error otherwise).
- Y_W, 5, width of each element's Y field (X fixed at 1 bit).

Ports:
- CLK  in  1  rising-edge clock; also wired to Memory CLK.
- ASYNCRESET  in  1  asynchronous, active-high reset.
- ENQ_VALID  in  1  producer has an element pair.
- ENQ_READY  out  1  FIFO can accept this cycle.
- ENQ_DATA_0_X, ENQ_DATA_1_X  in  1  element X fields.
- ENQ_DATA_0_Y, ENQ_DATA_1_Y  in  Y_W  element Y fields.
- DEQ_VALID  out  1  head entry available.
- DEQ_READY  in  1  consumer takes head this cycle.
- DEQ_DATA_0_X, DEQ_DATA_1_X  out  1  head X fields.
- DEQ_DATA_0_Y, DEQ_DATA_1_Y  out  Y_W  head Y fields.
- WADDR  out  ADDR_W  to Memory WADDR.
- WDATA_0_X, WDATA_1_X  out  1  to Memory.
- WDATA_0_Y, WDATA_1_Y  out  Y_W  to Memory.
- WE  out  1  to Memory WE.
- RADDR  out  ADDR_W  to Memory RADDR.
- RDATA_0_X, RDATA_1_X  in  1  from Memory.
- RDATA_0_Y, RDATA_1_Y  in  Y_W  from Memory.

Behaviour:
- State: wptr, rptr, each ADDR_W+1 bits (MSB is the wrap bit). No other sequential state.
- Reset: ASYNCRESET high clears wptr and rptr to 0 immediately, independent of CLK.
  - Hence DEQ_VALID=0, ENQ_READY=1, WE=0 (WE=0 while ASYNCRESET is asserted, regardless of ENQ_VALID), WADDR=0, RADDR=0.
- Flags (combinational from pointers):
  - empty = (wptr == rptr);
  - full = (low ADDR_W bits equal) AND (MSBs differ).
  - ENQ_READY = !full; DEQ_VALID = !empty.
- Handshakes:
  - enq_fire = ENQ_VALID & ENQ_READY; deq_fire = DEQ_VALID & DEQ_READY.
  - ENQ_READY does not depend on DEQ_READY (no full-bypass).
  - DEQ_VALID does not depend on ENQ_VALID (no empty-bypass).
- Write path:
  - WE = enq_fire; WADDR = wptr[ADDR_W-1:0].
  - WDATA_* = ENQ_DATA_* passed straight through.
  - On a CLK edge with enq_fire, wptr increments by 1, modulo 2**(ADDR_W+1).
- Read path:
  - RADDR = rptr[ADDR_W-1:0]; DEQ_DATA_* = RDATA_* (Memory read is asynchronous).
  - On a CLK edge with deq_fire, rptr increments by 1, modulo 2**(ADDR_W+1).
- Latency: an entry enqueued at edge N is visible on DEQ_VALID/DEQ_DATA after edge N (one cycle, first-word).
- Simultaneous enq_fire and deq_fire (possible only when neither empty nor full): both pointers advance; occupancy unchanged.
- Full: ENQ_VALID is ignored (WE stays 0); a dequeue that cycle frees a slot and ENQ_READY rises after the edge.
- Empty: DEQ_READY is ignored; DEQ_DATA is don't-care, and the bench must not check it while DEQ_VALID=0.
- Wrap-around: low address bits wrap 3->0 seamlessly; MSB toggles on each wrap.
- Reset mid-operation: contents of Memory are not cleared, but the FIFO reads as empty, so stale data is never presented with DEQ_VALID=1.
- Protocol: the producer must hold ENQ_DATA stable while ENQ_VALID=1 and !ENQ_READY.

Optional Feature:
- Macro: MEM_FIFO_LEVEL_EN.
- Defined:
  - adds output LEVEL [ADDR_W:0] = wptr - rptr (0..DEPTH), registered via the pointers, 0 on reset;
  - adds output ALMOST_FULL = (LEVEL >= DEPTH-1).
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- Reset then idle:
  - assert ASYNCRESET between edges -> DEQ_VALID=0, ENQ_READY=1, WE=0 immediately;
  - LEVEL=0 if MEM_FIFO_LEVEL_EN.
- Single element:
  - enqueue {0:{X=1,Y=5'h0A},1:{X=0,Y=5'h15}} with DEQ_READY=0 -> WE=1, WADDR=0 that cycle;
  - next cycle DEQ_VALID=1, DEQ_DATA matches;
  - DEQ_READY=1 one cycle -> DEQ_VALID=0 after.
- Fill to full:
  - 5 consecutive ENQ_VALID with Y=1..5 and DEQ_READY=0 -> first 4 accepted at WADDR 0..3;
  - ENQ_READY=0 on the 5th cycle, WE=0 there;
  - drain returns Y=1,2,3,4 in order.
- Full with simultaneous valid:
  - full, ENQ_VALID=1, DEQ_READY=1 -> only the dequeue fires;
  - ENQ_READY=1 next cycle; the 5th element is accepted at WADDR 0.
- Streaming wrap:
  - ENQ_VALID=DEQ_READY=1 for 12 cycles after one priming enqueue -> output sequence equals input sequence;
  - occupancy stays 1; WADDR/RADDR wrap 3->0 three times.
- Reset mid-stream:
  - with 3 entries queued, pulse ASYNCRESET -> DEQ_VALID=0 at once;
  - the next enqueue lands at WADDR=0 and is the first dequeued.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// Pointer/flag controller that turns the external 4x12 Memory into a synchronous FIFO.
// Optional LEVEL/ALMOST_FULL outputs are enabled by defining MEM_FIFO_LEVEL_EN.
module mem_fifo_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4,
    parameter int Y_W    = 5
) (
    input  logic              CLK,
    input  logic              ASYNCRESET,
    input  logic              ENQ_VALID,
    output logic              ENQ_READY,
    input  logic              ENQ_DATA_0_X,
    input  logic              ENQ_DATA_1_X,
    input  logic [Y_W-1:0]    ENQ_DATA_0_Y,
    input  logic [Y_W-1:0]    ENQ_DATA_1_Y,
    output logic              DEQ_VALID,
    input  logic              DEQ_READY,
    output logic              DEQ_DATA_0_X,
    output logic              DEQ_DATA_1_X,
    output logic [Y_W-1:0]    DEQ_DATA_0_Y,
    output logic [Y_W-1:0]    DEQ_DATA_1_Y,
    output logic [ADDR_W-1:0] WADDR,
    output logic              WDATA_0_X,
    output logic              WDATA_1_X,
    output logic [Y_W-1:0]    WDATA_0_Y,
    output logic [Y_W-1:0]    WDATA_1_Y,
    output logic              WE,
    output logic [ADDR_W-1:0] RADDR,
`ifdef MEM_FIFO_LEVEL_EN
    output logic [ADDR_W:0]   LEVEL,
    output logic              ALMOST_FULL,
`endif
    input  logic              RDATA_0_X,
    input  logic              RDATA_1_X,
    input  logic [Y_W-1:0]    RDATA_0_Y,
    input  logic [Y_W-1:0]    RDATA_1_Y
);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("mem_fifo_ctrl: DEPTH must equal 2**ADDR_W");
    end

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic            empty;
    logic            full;
    logic            enq_fire;
    logic            deq_fire;

    // Handshake: a transfer happens on a rising CLK edge when valid and ready
    // are both high; ENQ_READY depends only on fullness and DEQ_VALID only on
    // emptiness, so neither side combinationally bypasses the other.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
    assign ENQ_READY = !full;
    assign DEQ_VALID = !empty;
    assign enq_fire = ENQ_VALID && ENQ_READY;
    assign deq_fire = DEQ_VALID && DEQ_READY;

    // Reset also masks the write strobe so Memory is never written while held.
    assign WE        = enq_fire && !ASYNCRESET;
    assign WADDR     = wptr[ADDR_W-1:0];
    assign WDATA_0_X = ENQ_DATA_0_X;
    assign WDATA_1_X = ENQ_DATA_1_X;
    assign WDATA_0_Y = ENQ_DATA_0_Y;
    assign WDATA_1_Y = ENQ_DATA_1_Y;

    assign RADDR        = rptr[ADDR_W-1:0];
    assign DEQ_DATA_0_X = RDATA_0_X;
    assign DEQ_DATA_1_X = RDATA_1_X;
    assign DEQ_DATA_0_Y = RDATA_0_Y;
    assign DEQ_DATA_1_Y = RDATA_1_Y;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq_fire) wptr <= wptr + PTR_ONE;
            if (deq_fire) rptr <= rptr + PTR_ONE;
        end
    end

`ifdef MEM_FIFO_LEVEL_EN
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W + 1)'(DEPTH - 1);

    // The wrap bit makes the modular difference span 0..DEPTH exactly.
    assign LEVEL       = wptr - rptr;
    assign ALMOST_FULL = (LEVEL >= AF_LEVEL);
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl: behavioural Memory, queue-based reference
// model, scoreboard monitor. Define MEM_FIFO_LEVEL_EN to also check LEVEL/ALMOST_FULL.
module tb_mem_fifo_ctrl;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int Y_W    = 5;

    logic              CLK;
    logic              ASYNCRESET;
    logic              ENQ_VALID;
    logic              ENQ_READY;
    logic              ENQ_DATA_0_X, ENQ_DATA_1_X;
    logic [Y_W-1:0]    ENQ_DATA_0_Y, ENQ_DATA_1_Y;
    logic              DEQ_VALID;
    logic              DEQ_READY;
    logic              DEQ_DATA_0_X, DEQ_DATA_1_X;
    logic [Y_W-1:0]    DEQ_DATA_0_Y, DEQ_DATA_1_Y;
    logic [ADDR_W-1:0] WADDR;
    logic              WDATA_0_X, WDATA_1_X;
    logic [Y_W-1:0]    WDATA_0_Y, WDATA_1_Y;
    logic              WE;
    logic [ADDR_W-1:0] RADDR;
    logic              RDATA_0_X, RDATA_1_X;
    logic [Y_W-1:0]    RDATA_0_Y, RDATA_1_Y;
`ifdef MEM_FIFO_LEVEL_EN
    logic [ADDR_W:0]   LEVEL;
    logic              ALMOST_FULL;
`endif

    mem_fifo_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .Y_W(Y_W)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET),
        .ENQ_VALID(ENQ_VALID), .ENQ_READY(ENQ_READY),
        .ENQ_DATA_0_X(ENQ_DATA_0_X), .ENQ_DATA_1_X(ENQ_DATA_1_X),
        .ENQ_DATA_0_Y(ENQ_DATA_0_Y), .ENQ_DATA_1_Y(ENQ_DATA_1_Y),
        .DEQ_VALID(DEQ_VALID), .DEQ_READY(DEQ_READY),
        .DEQ_DATA_0_X(DEQ_DATA_0_X), .DEQ_DATA_1_X(DEQ_DATA_1_X),
        .DEQ_DATA_0_Y(DEQ_DATA_0_Y), .DEQ_DATA_1_Y(DEQ_DATA_1_Y),
        .WADDR(WADDR),
        .WDATA_0_X(WDATA_0_X), .WDATA_1_X(WDATA_1_X),
        .WDATA_0_Y(WDATA_0_Y), .WDATA_1_Y(WDATA_1_Y),
        .WE(WE), .RADDR(RADDR),
`ifdef MEM_FIFO_LEVEL_EN
        .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL),
`endif
        .RDATA_0_X(RDATA_0_X), .RDATA_1_X(RDATA_1_X),
        .RDATA_0_Y(RDATA_0_Y), .RDATA_1_Y(RDATA_1_Y)
    );

    // Behavioural Memory: synchronous write, asynchronous read; entry = {x1,y1,x0,y0}.
    logic [11:0] mem [DEPTH];
    always @(posedge CLK) if (WE) mem[WADDR] <= {WDATA_1_X, WDATA_1_Y, WDATA_0_X, WDATA_0_Y};
    assign {RDATA_1_X, RDATA_1_Y, RDATA_0_X, RDATA_0_Y} = mem[RADDR];

    // Clock/reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] exp_q[$];
    int          occ = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    bit          last_acc = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        occ = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        exp_q.delete();
    endtask

    // Driver: apply inputs after a falling edge, check combinational outputs
    // against the model, then commit the model's view of the coming edge.
    task automatic do_cycle(input bit ev, input bit dr, input logic [11:0] d);
        bit acc_enq;
        bit acc_deq;
        @(negedge CLK);
        ENQ_VALID = ev;
        DEQ_READY = dr;
        {ENQ_DATA_1_X, ENQ_DATA_1_Y, ENQ_DATA_0_X, ENQ_DATA_0_Y} = d;
        #1;
        acc_enq = ev && (occ < DEPTH);
        acc_deq = dr && (occ > 0);
        chk("enq_ready", int'(ENQ_READY), int'(occ < DEPTH));
        chk("deq_valid", int'(DEQ_VALID), int'(occ > 0));
        chk("we", int'(WE), int'(acc_enq));
        chk("waddr", int'(WADDR), wr_cnt % DEPTH);
        chk("raddr", int'(RADDR), rd_cnt % DEPTH);
        if (acc_enq)
            chk("wdata", int'({WDATA_1_X, WDATA_1_Y, WDATA_0_X, WDATA_0_Y}), int'(d));
`ifdef MEM_FIFO_LEVEL_EN
        chk("level", int'(LEVEL), occ);
        chk("almost_full", int'(ALMOST_FULL), int'(occ >= DEPTH - 1));
`endif
        if (acc_enq) begin
            exp_q.push_back(d);
            wr_cnt++;
            occ++;
        end
        if (acc_deq) begin
            rd_cnt++;
            occ--;
        end
        last_acc = acc_enq;
    endtask

    // Asynchronous reset pulse between edges, with ENQ_VALID high to prove WE is masked.
    task automatic pulse_reset();
        @(negedge CLK);
        ENQ_VALID = 1'b0;
        DEQ_READY = 1'b0;
        #3;
        ENQ_VALID = 1'b1;
        ASYNCRESET = 1'b1;
        #1;
        chk("rst_deq_valid", int'(DEQ_VALID), 0);
        chk("rst_enq_ready", int'(ENQ_READY), 1);
        chk("rst_we", int'(WE), 0);
        chk("rst_waddr", int'(WADDR), 0);
        chk("rst_raddr", int'(RADDR), 0);
`ifdef MEM_FIFO_LEVEL_EN
        chk("rst_level", int'(LEVEL), 0);
`endif
        ENQ_VALID = 1'b0;
        ASYNCRESET = 1'b0;
        model_reset();
    endtask

    function automatic logic [11:0] pair(input int y0, input int y1);
        logic x0;
        logic x1;
        x0 = 1'($urandom_range(0, 1));
        x1 = 1'($urandom_range(0, 1));
        return {x1, 5'(y1), x0, 5'(y0)};
    endfunction

    // Scoreboard monitor: pops whenever the DUT shows a dequeue handshake.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (DEQ_VALID && DEQ_READY) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: dequeue with empty expected queue at %0t", $time);
                end else begin
                    chk("deq_data", int'({DEQ_DATA_1_X, DEQ_DATA_1_Y, DEQ_DATA_0_X, DEQ_DATA_0_Y}),
                        int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [11:0] d;
        bit          ev;
        bit          dr;
        for (int i = 0; i < DEPTH; i++) mem[i] = 12'($urandom);
        ASYNCRESET = 1'b1;
        ENQ_VALID = 1'b0;
        DEQ_READY = 1'b0;
        {ENQ_DATA_1_X, ENQ_DATA_1_Y, ENQ_DATA_0_X, ENQ_DATA_0_Y} = '0;
        #12;
        ASYNCRESET = 1'b0;

        // Reset then idle
        pulse_reset();
        do_cycle(0, 0, 12'h0);
        do_cycle(0, 1, 12'h0);

        // Single element
        do_cycle(1, 0, {1'b0, 5'h15, 1'b1, 5'h0A});
        do_cycle(0, 0, 12'h0);
        do_cycle(0, 1, 12'h0);
        do_cycle(0, 0, 12'h0);

        // Fill to full, 5th refused, drain
        for (int i = 1; i <= 5; i++) do_cycle(1, 0, pair(i, i));
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 12'h0);
        do_cycle(0, 1, 12'h0);

        // Full with simultaneous valid: only dequeue fires, then 5th accepted
        for (int i = 1; i <= 4; i++) do_cycle(1, 0, pair(i, i + 8));
        d = pair(5, 13);
        do_cycle(1, 1, d);
        do_cycle(1, 0, d);
        for (int i = 0; i < 5; i++) do_cycle(0, 1, 12'h0);

        // Streaming wrap
        do_cycle(1, 0, 12'($urandom));
        for (int i = 0; i < 12; i++) do_cycle(1, 1, 12'($urandom));
        do_cycle(0, 1, 12'h0);
        do_cycle(0, 0, 12'h0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 12'($urandom));
        pulse_reset();
        do_cycle(0, 0, 12'h0);
        do_cycle(1, 0, 12'h5A5);
        do_cycle(0, 1, 12'h0);
        do_cycle(0, 0, 12'h0);

        // Randomized traffic; producer holds data while stalled
        ev = 0;
        d = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            else if (!(ev && !last_acc)) begin
                ev = ($urandom_range(0, 3) != 0);
                d = 12'($urandom);
            end
            dr = ($urandom_range(0, 2) != 0);
            do_cycle(ev, dr, d);
            if (i == 200) ev = 0;
        end
        for (int i = 0; i < DEPTH + 1; i++) do_cycle(0, 1, 12'h0);
        do_cycle(0, 0, 12'h0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
